// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//   UART receiver with oversampled start detection, DATA_BITS data bits (LSB
//   first), optional parity and STOP_BITS stop bits. Each frame is handed to
//   the host as one word on a valid/ready interface, with per-frame error
//   flags and an overrun pulse when a finished frame cannot be stored.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> one parity bit follows the data; parity_err reports it
//                  (PARITY_ODD selects even (0) or odd (1) parity)
//     undefined -> no parity bit, parity_err tied 0
//
// Ports
//   clk        in   system clock, the only clock
//   rst        in   synchronous reset, active-high
//   baud_tick  in   one-clk enable at OVS x baud rate
//   rxd        in   asynchronous serial input, idle high
//   rx_data    out  received word, stable while rx_valid=1
//   rx_valid   out  rx_data/flags hold a frame not yet accepted
//   rx_ready   in   consumer accepts when rx_valid & rx_ready
//   frame_err  out  with rx_valid: a stop bit was sampled 0
//   parity_err out  with rx_valid: parity mismatch
//   overrun    out  one-clk pulse: finished frame dropped, holding reg full
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVS        = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVS);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVS < 8 || OVS > 32 || (OVS % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_frame: illegal parameter set");
    end

`ifdef UART_RX_PARITY_EN
    localparam logic PODD = (PARITY_ODD != 0);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   armed_q, armed_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_done;
    logic                   rxs;
`ifdef UART_RX_PARITY_EN
    logic                   perr_acc_q, perr_acc_d;
    logic                   parity_err_q, parity_err_d;
`endif

    assign rxs = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], rxd};
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        ferr_acc_d  = ferr_acc_q;
        armed_d     = armed_q;
        frame_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_acc_d  = perr_acc_q;
`endif
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    // armed must see the line high first, so a held-low
                    // line (break) cannot start a new frame.
                    if (rxs) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        tcnt_d  = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (tcnt_q == HALF_LAST) begin
                        tcnt_d     = '0;
                        idx_d      = '0;
                        ferr_acc_d = 1'b0;
                        state_d    = rxs ? S_IDLE : S_DATA;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tcnt_q == FULL_LAST) begin
                        tcnt_d = '0;
                        // Shift in from the top: after DATA_BITS samples the
                        // first bit received sits in bit 0 (LSB first).
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        if (idx_q == DATA_LAST) begin
                            idx_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tcnt_q == FULL_LAST) begin
                        tcnt_d     = '0;
                        perr_acc_d = ((^shreg_q) ^ rxs) != PODD;
                        state_d    = S_STOP;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tcnt_q == FULL_LAST) begin
                        tcnt_d     = '0;
                        ferr_acc_d = ferr_acc_q | ~rxs;
                        if (idx_q == STOP_LAST) begin
                            // Complete at the stop centre, not the bit end,
                            // so back-to-back frames are never missed.
                            frame_done = 1'b1;
                            idx_d      = '0;
                            armed_d    = 1'b0;
                            state_d    = S_IDLE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Holding register: a completing frame may replace a word being accepted
    // in the same clk; otherwise a full register drops the new frame.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d   = shreg_q;
                rx_valid_d  = 1'b1;
                frame_err_d = ferr_acc_q | ~rxs;
`ifdef UART_RX_PARITY_EN
                parity_err_d = perr_acc_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            tcnt_q      <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            ferr_acc_q  <= 1'b0;
            armed_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            ferr_acc_q  <= ferr_acc_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            perr_acc_q   <= perr_acc_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//   Drives serial frames bit by bit (each bit held for OVS baud ticks) and
//   predicts, from the frame contents and the tick on which the start edge
//   was launched, which tick carries the last stop-bit centre. A
//   holding-register model then gives rx_valid/rx_data/flags/overrun for
//   every clk, compared against the DUT on each falling edge. Directed
//   scenarios also pin accepted words against literal values.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int DB   = 8;
    localparam int OVS  = 16;
    localparam int SB   = 1;
    localparam int PODD = 0;
    localparam bit PODD_B = (PODD != 0);
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 1 + DB + 1 + SB;
`else
    localparam int NBITS = 1 + DB + SB;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          baud_tick = 1'b0;
    logic          rxd = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    uart_rx_frame #(
        .DATA_BITS (DB),
        .OVS       (OVS),
        .STOP_BITS (SB),
        .PARITY_ODD(PODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint        t;     // tick number carrying the last stop centre
        logic [DB-1:0] d;
        bit            fe;
        bit            pe;
    } exp_t;

    exp_t          pend[$];
    longint        tick_cnt = 0;
    int            ready_pct = 100;
    bit            chk_en = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;

    bit            m_valid = 1'b0;
    bit            m_ovr = 1'b0;
    bit            m_fe = 1'b0;
    bit            m_pe = 1'b0;
    logic [DB-1:0] m_data = '0;

    int            acc_n = 0;
    int            ovr_n = 0;
    logic [DB-1:0] acc_d = '0;
    logic          acc_fe = 1'b0;
    logic          acc_pe = 1'b0;

    // baud ticks with random spacing of 3..5 clks
    initial begin
        int gap;
        gap = 3;
        forever begin
            @(posedge clk);
            #1;
            if (gap <= 1) begin
                baud_tick = 1'b1;
                gap = int'($urandom_range(5, 3));
            end else begin
                baud_tick = 1'b0;
                gap = gap - 1;
            end
        end
    end

    // consumer
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rx_ready = (int'($urandom_range(99, 0)) < ready_pct);
        end
    end

    // reference model: frame completion on the predicted tick, then the
    // holding-register / overrun rules
    initial begin
        exp_t f;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                m_data  = '0;
                m_fe    = 1'b0;
                m_pe    = 1'b0;
                pend.delete();
            end else begin
                m_ovr = 1'b0;
                if (baud_tick && pend.size() > 0 && pend[0].t == tick_cnt + 1) begin
                    f = pend.pop_front();
                    if (!m_valid || rx_ready) begin
                        m_valid = 1'b1;
                        m_data  = f.d;
                        m_fe    = f.fe;
                        m_pe    = f.pe;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_valid && rx_ready) begin
                    m_valid = 1'b0;
                end
            end
            if (baud_tick) tick_cnt = tick_cnt + 1;
        end
    end

    // per-cycle compare
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_vec = n_vec + 1;
                if (rx_valid !== m_valid || overrun !== m_ovr || rx_data !== m_data ||
                    frame_err !== m_fe || parity_err !== m_pe) begin
                    n_err = n_err + 1;
                    $display("FAIL cycle t=%0t: got valid=%b ovr=%b data=%h fe=%b pe=%b, want valid=%b ovr=%b data=%h fe=%b pe=%b",
                             $time, rx_valid, overrun, rx_data, frame_err, parity_err,
                             m_valid, m_ovr, m_data, m_fe, m_pe);
                end
            end
        end
    end

    // accepted-word / overrun monitor (acceptance happens at the next edge)
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rx_valid === 1'b1 && rx_ready === 1'b1) begin
                acc_n  = acc_n + 1;
                acc_d  = rx_data;
                acc_fe = frame_err;
                acc_pe = parity_err;
            end
            if (!rst && overrun === 1'b1) ovr_n = ovr_n + 1;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec = n_vec + 1;
        if (got !== want) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (baud_tick !== 1'b1);
        end
        #1;
    endtask

    // one frame; stop_bad drives the (first) stop bit 0, par_flip inverts
    // the parity bit (when parity is built in)
    task automatic send_frame(input logic [DB-1:0] d, input bit stop_bad,
                              input bit par_flip, input int gap);
        exp_t   f;
        bit     seq[$];
        longint e;
`ifdef UART_RX_PARITY_EN
        bit     pbit;
        pbit = (^d) ^ PODD_B ^ par_flip;
`endif
        seq.push_back(1'b0);
        for (int i = 0; i < DB; i++) seq.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        seq.push_back(pbit);
`endif
        for (int s = 0; s < SB; s++) seq.push_back(!(stop_bad && s == 0));
        wait_ticks(1);
        e    = tick_cnt;
        // start centre is OVS/2 ticks after the detecting tick (e+1),
        // every later bit OVS ticks further on
        f.t  = e + 1 + OVS / 2 + longint'(OVS) * (NBITS - 1);
        f.d  = d;
        f.fe = stop_bad;
`ifdef UART_RX_PARITY_EN
        f.pe = (((^d) ^ pbit) != PODD_B);
`else
        f.pe = 1'b0;
        if (par_flip) f.pe = 1'b0;
`endif
        pend.push_back(f);
        for (int i = 0; i < seq.size(); i++) begin
            rxd = seq[i];
            wait_ticks(OVS);
        end
        rxd = 1'b1;
        wait_ticks(gap);
    endtask

    task automatic send_break(input int nbits_low, input int gap);
        exp_t   f;
        longint e;
        wait_ticks(1);
        e    = tick_cnt;
        f.t  = e + 1 + OVS / 2 + longint'(OVS) * (NBITS - 1);
        f.d  = '0;
        f.fe = 1'b1;
`ifdef UART_RX_PARITY_EN
        f.pe = PODD_B;
`else
        f.pe = 1'b0;
`endif
        pend.push_back(f);
        rxd = 1'b0;
        wait_ticks(nbits_low * OVS);
        rxd = 1'b1;
        wait_ticks(gap);
    endtask

    initial begin
        int n0;
        int o0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(4);

        // T1: clean 0xA5
        ready_pct = 100;
        n0 = acc_n;
        send_frame(8'hA5, 1'b0, 1'b0, 8);
        check("t1_count", acc_n - n0, 1);
        check("t1_data", acc_d, 8'hA5);
        check("t1_ferr", acc_fe, 0);

        // T2: false start, then 0x3C
        n0 = acc_n;
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(6);
        rxd = 1'b1;
        wait_ticks(16);
        check("t2_false_start_count", acc_n - n0, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 8);
        check("t2_data", acc_d, 8'h3C);
        check("t2_count", acc_n - n0, 1);

        // T3: bad stop bit, then break held for three frame times
        send_frame(8'h55, 1'b1, 1'b0, 8);
        check("t3_data", acc_d, 8'h55);
        check("t3_ferr", acc_fe, 1);
        n0 = acc_n;
        send_break(3 * NBITS, 10);
        check("t3_break_count", acc_n - n0, 1);
        check("t3_break_data", acc_d, 0);
        check("t3_break_ferr", acc_fe, 1);

        // T4: overrun while consumer stalls
        ready_pct = 0;
        repeat (4) @(posedge clk);
        #1;
        n0 = acc_n;
        o0 = ovr_n;
        send_frame(8'h11, 1'b0, 1'b0, 4);
        send_frame(8'h22, 1'b0, 1'b0, 4);
        check("t4_overrun_pulses", ovr_n - o0, 1);
        check("t4_held_data", rx_data, 8'h11);
        check("t4_held_valid", rx_valid, 1);
        ready_pct = 100;
        repeat (3) @(posedge clk);
        #1;
        check("t4_valid_cleared", rx_valid, 0);
        check("t4_accepted", acc_d, 8'h11);
        check("t4_count", acc_n - n0, 1);

`ifdef UART_RX_PARITY_EN
        // T5: 0x07 has odd weight, even parity bit would be 1
        send_frame(8'h07, 1'b0, 1'b1, 8);
        check("t5_parity_bad", acc_pe, 1);
        send_frame(8'h07, 1'b0, 1'b0, 8);
        check("t5_parity_good", acc_pe, 0);
`endif

        // T6: reset in the middle of the data bits of 0xFF
        n0 = acc_n;
        fork
            send_frame(8'hFF, 1'b0, 1'b0, 8);
            begin
                wait_ticks(1 + OVS / 2 + OVS * 3);
                rst = 1'b1;
                @(posedge clk);
                #1;
                check("t6_rst_valid", rx_valid, 0);
                check("t6_rst_data", rx_data, 0);
                check("t6_rst_ferr", frame_err, 0);
                rst = 1'b0;
            end
        join
        check("t6_dropped", acc_n - n0, 0);
        send_frame(8'h81, 1'b0, 1'b0, 8);
        check("t6_data", acc_d, 8'h81);
        check("t6_ferr", acc_fe, 0);
        check("t6_count", acc_n - n0, 1);

        // randomized frames with varying consumer behaviour
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(2, 0))
                0:       ready_pct = 0;
                1:       ready_pct = 30;
                default: ready_pct = 100;
            endcase
            send_frame(8'($urandom), ($urandom_range(7, 0) == 0), 1'($urandom),
                       int'($urandom_range(12, 2)));
        end
        ready_pct = 100;
        wait_ticks(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
